// File: rtl/seq_shift_reg_pkg.sv
// Shared types for the sequential shift/rotate register: shift-mode encoding
// and the controller state set.
package shift_pkg;

  typedef enum logic [2:0] {
    OP_SHL  = 3'd0,
    OP_SHR  = 3'd1,
    OP_ROTL = 3'd2,
    OP_ROTR = 3'd3,
    OP_ASR  = 3'd4,
    OP_LSL  = 3'd5,
    OP_LSR  = 3'd6,
    OP_HOLD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_shift_reg_if.sv
// Request/result bundle between a caller and seq_shift_reg.
interface seq_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] din;
  logic [CNT_W-1:0] amount;
  logic             sin;
  logic [WIDTH-1:0] dout;
  logic             sout;
  logic             busy;
  logic             done;

  modport master (
    output start, op, din, amount, sin,
    input  dout, sout, busy, done
  );

  modport slave (
    input  start, op, din, amount, sin,
    output dout, sout, busy, done
  );
endinterface

// File: rtl/seq_shift_reg_step.sv
// One single-bit step of every shift mode; purely combinational.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  op_e              op_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] data_o,
  output logic             out_bit_o
);

  // Select next data and the bit leaving the register for the requested mode
  always_comb begin
    data_o    = data_i;
    out_bit_o = 1'b0;
    case (op_i)
      OP_SHL: begin
        data_o    = {data_i[WIDTH-2:0], sin_i};
        out_bit_o = data_i[WIDTH-1];
      end
      OP_SHR: begin
        data_o    = {sin_i, data_i[WIDTH-1:1]};
        out_bit_o = data_i[0];
      end
      OP_ROTL: begin
        data_o    = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
        out_bit_o = data_i[WIDTH-1];
      end
      OP_ROTR: begin
        data_o    = {data_i[0], data_i[WIDTH-1:1]};
        out_bit_o = data_i[0];
      end
      OP_ASR: begin
        data_o    = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
        out_bit_o = data_i[0];
      end
      OP_LSL: begin
        data_o    = {data_i[WIDTH-2:0], 1'b0};
        out_bit_o = data_i[WIDTH-1];
      end
      OP_LSR: begin
        data_o    = {1'b0, data_i[WIDTH-1:1]};
        out_bit_o = data_i[0];
      end
      default: begin
        data_o    = data_i;
        out_bit_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shift_reg.sv
// Multi-position shift/rotate register stepping one bit per clock, driven by a
// start/busy/done handshake. busy and done are registered state decodes.
module seq_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic          clk,
  input logic          rst_n,
  seq_shift_reg_if.slave bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sout_q, sout_d;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] step_data;
  logic             step_bit;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .data_i    (data_q),
    .op_i      (op_q),
    .sin_i     (bus.sin),
    .data_o    (step_data),
    .out_bit_o (step_bit)
  );

  // Next-state, load and step logic; DONE accepts start just like IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    sout_d  = sout_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          data_d  = bus.din;
          cnt_d   = bus.amount;
          op_d    = op_e'(bus.op);
          state_d = (bus.amount != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_d = step_data;
        if (op_q != OP_HOLD) begin
          sout_d = step_bit;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_SHL;
      data_q  <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.dout = data_q;
  assign bus.sout = sout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_seq_shift_reg.sv
// Self-checking bench for seq_shift_reg: directed cases plus random operations
// against an arithmetic reference model.
module tb_seq_shift_reg;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
  localparam int unsigned M = 1 << W;
  localparam int unsigned H = M / 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_shift_reg_if #(.WIDTH(W), .CNT_W(CW)) bus();

  seq_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;
  int unsigned m_sout = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One step of the requested mode, expressed as arithmetic on an unsigned value
  function automatic int unsigned ref_step(input int unsigned v, input int op, input int unsigned s);
    int unsigned r;
    r = v;
    case (op)
      0: begin r = (v * 2 + s) % M;       m_sout = v / H; end
      1: begin r = v / 2 + s * H;         m_sout = v % 2; end
      2: begin r = (v * 2) % M + v / H;   m_sout = v / H; end
      3: begin r = v / 2 + (v % 2) * H;   m_sout = v % 2; end
      4: begin r = v / 2 + ((v >= H) ? H : 0); m_sout = v % 2; end
      5: begin r = (v * 2) % M;           m_sout = v / H; end
      6: begin r = v / 2;                 m_sout = v % 2; end
      default: r = v;
    endcase
    return r;
  endfunction

  int unsigned last_result;

  task automatic run_op(input int op, input int unsigned d, input int amt, input int unsigned s, input string tag);
    int unsigned v;
    v = d;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'(op); bus.din = W'(d); bus.amount = CW'(amt); bus.sin = s[0];
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= amt + 1; i++) begin
      @(negedge clk);
      if (i > 1) v = ref_step(v, op, s);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      check({tag, "_done"}, 32'(bus.done), 32'(i == amt + 1));
      check({tag, "_dout"}, 32'(bus.dout), v);
    end
    check({tag, "_sout"}, 32'(bus.sout), m_sout);
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    check({tag, "_hold_dout"}, 32'(bus.dout), v);
    last_result = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned v, v2;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 3'd0; bus.din = '0; bus.amount = '0; bus.sin = 1'b0;
    #1;
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_sout", 32'(bus.sout), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(0, 32'hB1, 3, 1, "shl");
    check("shl_val", 32'(bus.dout), 32'h8F);
    check("shl_so", 32'(bus.sout), 32'd1);

    run_op(4, 32'h90, 2, 0, "asr");
    check("asr_val", 32'(bus.dout), 32'hE4);
    check("asr_so", 32'(bus.sout), 32'd0);

    run_op(3, 32'hA5, 8, 0, "rotr");
    check("rotr_val", 32'(bus.dout), 32'hA5);
    check("rotr_so", 32'(bus.sout), 32'd1);

    run_op(5, 32'h3C, 0, 0, "amt0");
    check("amt0_val", 32'(bus.dout), 32'h3C);
    check("amt0_so", 32'(bus.sout), 32'd1);

    // start held during SHIFT (ignored) and through DONE (accepted back-to-back)
    v = 32'h0F;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.din = 8'h0F; bus.amount = CW'(3); bus.sin = 1'b0;
    @(posedge clk);
    #1 bus.din = 8'hFF; bus.op = 3'd2; bus.amount = CW'(2);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i > 1) v = ref_step(v, 5, 0);
      check("hs1_busy", 32'(bus.busy), 32'd1);
      check("hs1_done", 32'(bus.done), 32'(i == 4));
      check("hs1_dout", 32'(bus.dout), v);
      if (i == 4) bus.din = 8'h81;
    end
    check("hs1_val", 32'(bus.dout), 32'h78);
    @(posedge clk);
    #1 bus.start = 1'b0;
    v2 = 32'h81;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i > 1) v2 = ref_step(v2, 2, 0);
      check("hs2_busy", 32'(bus.busy), 32'd1);
      check("hs2_done", 32'(bus.done), 32'(i == 3));
      check("hs2_dout", 32'(bus.dout), v2);
    end
    check("hs2_val", 32'(bus.dout), 32'h06);
    check("hs2_so", 32'(bus.sout), m_sout);
    @(negedge clk);
    check("hs2_idle", 32'(bus.busy), 32'd0);

    // asynchronous reset in the middle of an LSR
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd6; bus.din = 8'h80; bus.amount = CW'(5); bus.sin = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_dout", 32'(bus.dout), 32'h20);
    check("mid_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", 32'(bus.dout), 32'd0);
    check("arst_sout", 32'(bus.sout), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    m_sout = 0;
    repeat (3) begin
      @(negedge clk);
      check("arst_nodone", 32'(bus.done), 32'd0);
      check("arst_nobusy", 32'(bus.busy), 32'd0);
    end
    rst_n = 1'b1;
    run_op(6, 32'h80, 5, 0, "post_rst");
    check("post_rst_val", 32'(bus.dout), 32'h04);

    // random operations, including amounts larger than the width
    for (int n = 0; n < 25; n++) begin
      run_op(int'($urandom_range(0, 7)), $urandom_range(0, M - 1),
             int'($urandom_range(0, (1 << CW) - 1)), $urandom_range(0, 1), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
